sd_rd_arbiter: RTL and testbench

SD_RD_ARBITER -- requirements
Module: sd_rd_arbiter

---
 rtl/sd_arb_pkg.sv | 14 +
 rtl/rr_arbiter.sv | 28 ++
 rtl/sd_rd_arbiter.sv | 168 ++++++++++++++++
 tb/tb_sd_rd_arbiter.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/sd_arb_pkg.sv
// rtl/sd_arb_pkg.sv - shared types and constants for the SD sector-read arbiter
package sd_arb_pkg;

    typedef enum logic [1:0] {
        S_IDLE,
        S_START,
        S_XFER,
        S_RELEASE
    } state_e;

    localparam int SECTOR_BYTES    = 512;
    localparam int DEFAULT_TIMEOUT = 65535;

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - combinational round-robin pick starting after the last granted index
module rr_arbiter #(
    parameter int PORTS = 2,
    parameter int IDXW  = 1
) (
    input  logic [PORTS-1:0] req,
    input  logic [IDXW-1:0]  last_idx,
    output logic             valid,
    output logic [IDXW-1:0]  winner
);

    logic [IDXW-1:0] cand;

    // Walk from farthest to nearest so the nearest requester after last_idx wins.
    always_comb begin
        valid  = 1'b0;
        winner = last_idx;
        cand   = '0;
        for (int k = PORTS; k >= 1; k--) begin
            cand = IDXW'((int'(last_idx) + k) % PORTS);
            if (req[cand]) begin
                valid  = 1'b1;
                winner = cand;
            end
        end
    end

endmodule

// File: rtl/sd_rd_arbiter.sv
// rtl/sd_rd_arbiter.sv - round-robin sharing of one sd_card sector-read port among PORTS clients
module sd_rd_arbiter
    import sd_arb_pkg::*;
#(
    parameter int PORTS   = 2,
    parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
    input  logic                clk,
    input  logic                rstn,
    input  logic [PORTS-1:0]    req,
    input  logic [PORTS*32-1:0] req_lba,
    output logic [PORTS-1:0]    ack,
    output logic [PORTS-1:0]    done,
    output logic [PORTS-1:0]    err,
    output logic [PORTS-1:0]    strobe,
    output logic [8:0]          addr,
    output logic [7:0]          data,
    output logic                sd_rstart,
    output logic [31:0]         sd_rsector,
    input  logic                sd_rbusy,
    input  logic                sd_rdone,
    input  logic                sd_outen,
    input  logic [8:0]          sd_outaddr,
    input  logic [7:0]          sd_outbyte
);

    localparam int IDXW = (PORTS > 1) ? $clog2(PORTS) : 1;

    state_e            state_q, state_d;
    logic [IDXW-1:0]   last_q, last_d, win_q, win_d;
    logic [PORTS-1:0]  ack_q, ack_d, done_q, done_d, err_q, err_d, strobe_q, strobe_d;
    logic [8:0]        addr_q, addr_d;
    logic [7:0]        data_q, data_d;
    logic              rstart_q, rstart_d;
    logic [31:0]       rsector_q, rsector_d;
    logic [9:0]        cnt_q, cnt_d;
    logic [31:0]       tmo_q, tmo_d;
    logic              pend_q, pend_d;

    logic              arb_valid;
    logic [IDXW-1:0]   arb_win;
    logic [31:0]       lba_arr [PORTS];

    for (genvar i = 0; i < PORTS; i++) begin : g_lba
        assign lba_arr[i] = req_lba[32*i +: 32];
    end

    rr_arbiter #(
        .PORTS (PORTS),
        .IDXW  (IDXW)
    ) u_rr (
        .req      (req),
        .last_idx (last_q),
        .valid    (arb_valid),
        .winner   (arb_win)
    );

    always_comb begin
        state_d   = state_q;
        last_d    = last_q;
        win_d     = win_q;
        ack_d     = ack_q;
        done_d    = '0;
        err_d     = '0;
        strobe_d  = '0;
        addr_d    = addr_q;
        data_d    = data_q;
        rstart_d  = rstart_q;
        rsector_d = rsector_q;
        cnt_d     = cnt_q;
        tmo_d     = tmo_q;
        pend_d    = pend_q;
        case (state_q)
            S_IDLE: begin
                if (arb_valid) begin
                    win_d          = arb_win;
                    rsector_d      = lba_arr[arb_win];
                    ack_d[arb_win] = 1'b1;
                    cnt_d          = '0;
                    tmo_d          = '0;
                    pend_d         = 1'b0;
                    rstart_d       = 1'b1;
                    state_d        = S_START;
                end
            end
            S_START: begin
                if (sd_rbusy) begin
                    rstart_d = 1'b0;
                    state_d  = S_XFER;
                end else if (tmo_q >= 32'(TIMEOUT - 1)) begin
                    rstart_d      = 1'b0;
                    done_d[win_q] = 1'b1;
                    err_d[win_q]  = 1'b1;
                    state_d       = S_RELEASE;
                end else begin
                    tmo_d = tmo_q + 32'd1;
                end
            end
            S_XFER: begin
                strobe_d[win_q] = sd_outen;
                if (sd_outen) begin
                    addr_d = sd_outaddr;
                    data_d = sd_outbyte;
                    cnt_d  = cnt_q + 10'd1;
                end
                // An rdone alongside the last byte waits a cycle so done trails that byte's strobe.
                if (pend_q || (sd_rdone && !sd_outen)) begin
                    done_d[win_q] = 1'b1;
                    err_d[win_q]  = (cnt_q != 10'(SECTOR_BYTES));
                    pend_d        = 1'b0;
                    state_d       = S_RELEASE;
                end else if (sd_rdone) begin
                    pend_d = 1'b1;
                end
            end
            S_RELEASE: begin
                ack_d[win_q] = 1'b0;
                last_d       = win_q;
                state_d      = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q   <= S_IDLE;
            last_q    <= IDXW'(PORTS - 1);
            win_q     <= '0;
            ack_q     <= '0;
            done_q    <= '0;
            err_q     <= '0;
            strobe_q  <= '0;
            addr_q    <= '0;
            data_q    <= '0;
            rstart_q  <= 1'b0;
            rsector_q <= '0;
            cnt_q     <= '0;
            tmo_q     <= '0;
            pend_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            last_q    <= last_d;
            win_q     <= win_d;
            ack_q     <= ack_d;
            done_q    <= done_d;
            err_q     <= err_d;
            strobe_q  <= strobe_d;
            addr_q    <= addr_d;
            data_q    <= data_d;
            rstart_q  <= rstart_d;
            rsector_q <= rsector_d;
            cnt_q     <= cnt_d;
            tmo_q     <= tmo_d;
            pend_q    <= pend_d;
        end
    end

    assign ack        = ack_q;
    assign done       = done_q;
    assign err        = err_q;
    assign strobe     = strobe_q;
    assign addr       = addr_q;
    assign data       = data_q;
    assign sd_rstart  = rstart_q;
    assign sd_rsector = rsector_q;

endmodule

// File: tb/tb_sd_rd_arbiter.sv
// tb/tb_sd_rd_arbiter.sv - scoreboard bench for sd_rd_arbiter with a behavioural sd_card model
module tb_sd_rd_arbiter;

    localparam int PORTS = 2;
    localparam int TMO   = 16;

    logic        clk = 1'b0;
    logic        rstn;
    logic [1:0]  req;
    logic [63:0] req_lba;
    logic [1:0]  ack, done, err, strobe;
    logic [8:0]  addr;
    logic [7:0]  data;
    logic        sd_rstart;
    logic [31:0] sd_rsector;
    logic        sd_rbusy, sd_rdone, sd_outen;
    logic [8:0]  sd_outaddr;
    logic [7:0]  sd_outbyte;

    sd_rd_arbiter #(.PORTS(PORTS), .TIMEOUT(TMO)) dut (
        .clk(clk), .rstn(rstn), .req(req), .req_lba(req_lba),
        .ack(ack), .done(done), .err(err), .strobe(strobe),
        .addr(addr), .data(data), .sd_rstart(sd_rstart), .sd_rsector(sd_rsector),
        .sd_rbusy(sd_rbusy), .sd_rdone(sd_rdone), .sd_outen(sd_outen),
        .sd_outaddr(sd_outaddr), .sd_outbyte(sd_outbyte)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          client;
        logic [31:0] lba;
        int          nbytes;
        bit          err;
        bit          coinc;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   passes = 0;
    int   last_model = PORTS - 1;
    int   card_n = 512;
    bit   card_coinc = 1'b0;
    bit   card_never = 1'b0;
    bit   noise = 1'b0;
    int   cyc = 0, byte_idx = 0, last_strobe_cyc = 0;
    int   rstart_run = 0, last_rstart_len = 0, done_count = 0;

    function automatic logic [7:0] pat(input logic [31:0] lba, input int i);
        return lba[7:0] + 8'(i * 7) + 8'(i / 256);
    endfunction

    task automatic chk(input string name, input bit ok, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (ok) passes++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // sd_card model: busy 3 cycles after rstart, byte stream with random gaps, then rdone
    initial begin
        sd_rbusy = 1'b0; sd_rdone = 1'b0; sd_outen = 1'b0; sd_outaddr = '0; sd_outbyte = '0;
        forever begin
            @(posedge clk); #1;
            if (rstn && sd_rstart && !card_never) begin
                sd_outen = 1'b0;
                repeat (3) @(posedge clk);
                #1 sd_rbusy = 1'b1;
                @(posedge clk); #1;
                for (int i = 0; i < card_n; i++) begin
                    if (!rstn) break;
                    if ($urandom_range(0, 1) == 1) begin @(posedge clk); #1; end
                    if (!rstn) break;
                    sd_outen   = 1'b1;
                    sd_outaddr = 9'(i);
                    sd_outbyte = pat(sd_rsector, i);
                    sd_rdone   = card_coinc && (i == card_n - 1);
                    @(posedge clk); #1;
                    sd_outen = 1'b0;
                    sd_rdone = 1'b0;
                end
                if (rstn && !card_coinc) begin
                    repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
                    sd_rdone = 1'b1;
                    @(posedge clk); #1;
                    sd_rdone = 1'b0;
                end
                sd_rbusy = 1'b0;
            end else begin
                sd_outen = (noise && rstn) ? 1'($urandom_range(0, 1)) : 1'b0;
            end
        end
    end

    always @(negedge clk) begin : monitor
        exp_t e;
        cyc++;
        if (sd_rstart) rstart_run++;
        else begin
            if (rstart_run != 0) last_rstart_len = rstart_run;
            rstart_run = 0;
        end
        if (rstn) begin
            if (strobe != 2'b00) begin
                if (exp_q.size() == 0) chk("unexpected_strobe", 1'b0, strobe, 0);
                else begin
                    e = exp_q[0];
                    chk("strobe_grant", strobe == 2'(1 << e.client), strobe, 1 << e.client);
                    chk("ack_during_strobe", ack[e.client] == 1'b1, ack, 1 << e.client);
                    chk("addr", addr == 9'(byte_idx), addr, byte_idx);
                    chk("data", data == pat(e.lba, byte_idx), data, pat(e.lba, byte_idx));
                    byte_idx++;
                    last_strobe_cyc = cyc;
                end
            end
            if (done != 2'b00) begin
                done_count++;
                if (exp_q.size() == 0) chk("unexpected_done", 1'b0, done, 0);
                else begin
                    e = exp_q.pop_front();
                    chk("done_client", done == 2'(1 << e.client), done, 1 << e.client);
                    chk("err", err == (e.err ? 2'(1 << e.client) : 2'b00), err, e.err ? (1 << e.client) : 0);
                    chk("ack_at_done", ack == 2'(1 << e.client), ack, 1 << e.client);
                    chk("byte_count", byte_idx == e.nbytes, byte_idx, e.nbytes);
                    chk("rsector", sd_rsector == e.lba, sd_rsector, e.lba);
                    if (e.nbytes > 0) begin
                        if (e.coinc) chk("done_one_after_last_strobe", cyc - last_strobe_cyc == 1, cyc - last_strobe_cyc, 1);
                        else chk("done_after_last_strobe", cyc - last_strobe_cyc >= 1, cyc - last_strobe_cyc, 1);
                    end
                    byte_idx = 0;
                end
            end else if (err != 2'b00) begin
                chk("err_without_done", 1'b0, err, 0);
            end
        end
    end

    task automatic wait_ack(input int c);
        int n = 0;
        while (ack[c] !== 1'b1 && n < 5000) begin @(negedge clk); n++; end
        chk("ack_rise", ack[c] === 1'b1, ack, 1 << c);
    endtask

    task automatic wait_empty();
        int n = 0;
        while (exp_q.size() != 0 && n < 20000) begin @(negedge clk); n++; end
        chk("transfers_complete", exp_q.size() == 0, exp_q.size(), 0);
        exp_q.delete();
        repeat (3) @(negedge clk);
    endtask

    // Round-robin reference: service order is the requesters in index order after the last served.
    task automatic issue(input logic [1:0] mask, input logic [31:0] l0, input logic [31:0] l1,
                         input int n, input bit coinc, input bit never);
        int          order[$];
        logic [31:0] l[2];
        l[0] = l0; l[1] = l1;
        card_n = n; card_coinc = coinc; card_never = never;
        for (int k = 1; k <= PORTS; k++) begin
            int c;
            c = (last_model + k) % PORTS;
            if (mask[c]) order.push_back(c);
        end
        foreach (order[j])
            exp_q.push_back('{order[j], l[order[j]], never ? 0 : n, never || (n != 512), coinc});
        last_model = order[order.size() - 1];
        req_lba = {l1, l0};
        req     = mask;
        foreach (order[j]) begin
            wait_ack(order[j]);
            req[order[j]] = 1'b0;
            req_lba[order[j]*32 +: 32] = $urandom;
        end
        wait_empty();
    endtask

    initial begin
        #800000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int n, cnt, dc;
        rstn = 1'b0; req = '0; req_lba = '0;
        repeat (3) @(negedge clk);
        chk("reset_outputs", {ack, done, err, strobe, addr, data, sd_rstart, sd_rsector} == '0,
            {ack, done, err, strobe, addr, data, sd_rstart}, 0);
        rstn = 1'b1;

        noise = 1'b1; cnt = 0;
        repeat (20) begin @(negedge clk); if (strobe != 2'b00) cnt++; end
        noise = 1'b0;
        chk("no_strobe_outside_xfer", cnt == 0, cnt, 0);
        repeat (3) @(negedge clk);

        issue(2'b01, 32'h10, $urandom, 512, 1'b0, 1'b0);
        issue(2'b11, $urandom, $urandom, 512, 1'b0, 1'b0);
        issue(2'b10, $urandom, $urandom, 512, 1'b1, 1'b0);
        issue(2'b11, $urandom, $urandom, 512, 1'b0, 1'b0);

        issue(2'b01, $urandom, $urandom, 0, 1'b0, 1'b1);
        chk("timeout_rstart_len", last_rstart_len == TMO, last_rstart_len, TMO);
        chk("timeout_ack_clear", ack == 2'b00, ack, 0);

        issue(2'b10, $urandom, $urandom, 500, 1'b0, 1'b0);
        issue(2'b01, $urandom, $urandom, 512, 1'b1, 1'b0);
        issue(2'b10, $urandom, $urandom, 300, 1'b1, 1'b0);

        card_n = 512; card_coinc = 1'b0; card_never = 1'b0;
        exp_q.push_back('{0, 32'h55, 512, 1'b0, 1'b0});
        last_model = 0;
        req_lba[31:0] = 32'h55; req = 2'b01;
        wait_ack(0);
        req = 2'b00;
        n = 0;
        while (byte_idx < 200 && n < 5000) begin @(negedge clk); n++; end
        chk("reached_byte_200", byte_idx >= 200, byte_idx, 200);
        dc = done_count;
        rstn = 1'b0;
        exp_q.delete();
        byte_idx = 0;
        @(negedge clk);
        chk("midxfer_reset_outputs", {ack, done, err, strobe, addr, data, sd_rstart, sd_rsector} == '0,
            {ack, done, err, strobe, addr, data, sd_rstart}, 0);
        repeat (3) @(negedge clk);
        rstn = 1'b1;
        last_model = PORTS - 1;
        repeat (30) @(negedge clk);
        chk("no_done_after_reset", done_count == dc, done_count - dc, 0);

        issue(2'b01, $urandom, $urandom, 512, 1'b0, 1'b0);

        for (int it = 0; it < 4; it++) begin
            logic [1:0] m;
            int         nb;
            m  = 2'($urandom_range(1, 3));
            nb = ($urandom_range(0, 1) == 1) ? 512 : int'($urandom_range(1, 511));
            issue(m, $urandom, $urandom, nb, 1'($urandom_range(0, 1)), 1'b0);
        end

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
